// File: rtl/calcn_pkg.sv
// Shared types and default sizing for the N-port calculator core.
package calcn_pkg;

    localparam int CALCN_NPORTS = 4;
    localparam int CALCN_DW     = 32;
    localparam int CALCN_TAGW   = 2;
    localparam int CALCN_DEPTH  = 4;
    localparam int CMD_W        = 4;
    localparam int RESP_W       = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    // Request as queued per port, at the default operand and tag widths.
    typedef struct packed {
        cmd_e                  cmd;
        logic [CALCN_DW-1:0]   data1;
        logic [CALCN_DW-1:0]   data2;
        logic [CALCN_TAGW-1:0] tag;
    } req_t;

    // Round-robin candidate: the port 'offset' places above 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/calcn_fifo.sv
// Synchronous per-port request FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module calcn_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calcn_core.sv
// N-port calculator core: per-port FIFOs, round-robin arbiter, shared ALU.
// Shift commands (5, 6) are built only when CALCN_SHIFT_EN is defined.
module calcn_core
    import calcn_pkg::*;
#(
    parameter int NPORTS     = CALCN_NPORTS,
    parameter int DW         = CALCN_DW,
    parameter int TAGW       = CALCN_TAGW,
    parameter int FIFO_DEPTH = CALCN_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NPORTS*4-1:0]    req_cmd,
    input  logic [NPORTS*DW-1:0]   req_data1,
    input  logic [NPORTS*DW-1:0]   req_data2,
    input  logic [NPORTS*TAGW-1:0] req_tag,
    output logic [NPORTS-1:0]      req_ready,
    output logic [NPORTS*2-1:0]    out_resp,
    output logic [NPORTS*TAGW-1:0] out_tag,
    output logic [NPORTS*DW-1:0]   out_data
);

    localparam int PW = $clog2(NPORTS);

    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [DW-1:0]    data1;
        logic [DW-1:0]    data2;
        logic [TAGW-1:0]  tag;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] empty;
    entry_t            wr_entry [NPORTS];
    entry_t            head     [NPORTS];

    logic [PW-1:0]     last_grant;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     cand;
    logic              grant_valid;
    entry_t            sel;
    logic [DW:0]       sum;
    resp_e             alu_resp;
    logic [DW-1:0]     alu_data;

    // Ready is purely !full: a full FIFO refuses even when it pops this edge.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign wr_entry[p] = '{cmd:   req_cmd[p*4 +: 4],
                               data1: req_data1[p*DW +: DW],
                               data2: req_data2[p*DW +: DW],
                               tag:   req_tag[p*TAGW +: TAGW]};
        assign push[p]      = (req_cmd[p*4 +: 4] != CMD_NONE) && !full[p];
        assign pop[p]       = grant_valid && (grant_idx == PW'(p));
        assign req_ready[p] = !full[p];

        calcn_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (wr_entry[p]),
            .full  (full[p]),
            .empty (empty[p]),
            .head  (head[p])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = PW'(rr_index(int'(last_grant), i, NPORTS));
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel      = head[grant_idx];
        sum      = {1'b0, sel.data1} + {1'b0, sel.data2};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (sel.cmd)
            CMD_ADD: begin
                if (!sum[DW]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (sel.data2 <= sel.data1) begin
                    alu_resp = RESP_OK;
                    alu_data = sel.data1 - sel.data2;
                end
            end
`ifdef CALCN_SHIFT_EN
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = sel.data1 << sel.data2[$clog2(DW)-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = sel.data1 >> sel.data2[$clog2(DW)-1:0];
            end
`endif
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    // Outputs are one-cycle pulses: every port clears unless granted this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PW'(NPORTS - 1);
            out_resp   <= '0;
            out_tag    <= '0;
            out_data   <= '0;
        end else begin
            out_resp <= '0;
            out_tag  <= '0;
            out_data <= '0;
            if (grant_valid) begin
                last_grant                             <= grant_idx;
                out_resp[int'(grant_idx)*2 +: 2]       <= alu_resp;
                out_tag[int'(grant_idx)*TAGW +: TAGW]  <= sel.tag;
                out_data[int'(grant_idx)*DW +: DW]     <= alu_data;
            end
        end
    end

endmodule

// File: tb/tb_calcn_core.sv
// Self-checking bench for calcn_core against a queue-based reference model.
module tb_calcn_core;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int TW    = 2;
    localparam int DEPTH = 4;

    logic               clk;
    logic               reset;
    logic [NP*4-1:0]    req_cmd;
    logic [NP*DW-1:0]   req_data1;
    logic [NP*DW-1:0]   req_data2;
    logic [NP*TW-1:0]   req_tag;
    logic [NP-1:0]      req_ready;
    logic [NP*2-1:0]    out_resp;
    logic [NP*TW-1:0]   out_tag;
    logic [NP*DW-1:0]   out_data;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [TW-1:0] tag;
    } mreq_t;

    mreq_t         mq [NP][$];
    int            last_g;
    logic [1:0]    exp_resp [NP];
    logic [TW-1:0] exp_tag  [NP];
    logic [DW-1:0] exp_data [NP];
    logic [NP-1:0] exp_ready;
    logic [NP-1:0] seen_ready;
    int            n_vec;
    int            n_miss;

    calcn_core #(
        .NPORTS     (NP),
        .DW         (DW),
        .TAGW       (TW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_cmd   (req_cmd),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .out_resp  (out_resp),
        .out_tag   (out_tag),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural ALU: the result must fit in DW bits, otherwise it is an error.
    function automatic void ref_alu(input logic [3:0] cmd, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b, output logic [1:0] r,
                                    output logic [DW-1:0] d);
        r = 2'd2;
        d = '0;
        case (cmd)
            4'd1: if (64'(a) + 64'(b) < 64'h1_0000_0000) begin r = 2'd1; d = a + b; end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
`ifdef CALCN_SHIFT_EN
            4'd5: begin r = 2'd1; d = a << (b % DW); end
            4'd6: begin r = 2'd1; d = a >> (b % DW); end
`endif
            default: ;
        endcase
    endfunction

    function automatic bit model_busy();
        for (int p = 0; p < NP; p++) begin
            if (mq[p].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic set_req(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [TW-1:0] t);
        req_cmd[p*4 +: 4]     = c;
        req_data1[p*DW +: DW] = a;
        req_data2[p*DW +: DW] = b;
        req_tag[p*TW +: TW]   = t;
    endtask

    task automatic clear_reqs();
        req_cmd   = '0;
        req_data1 = '0;
        req_data2 = '0;
        req_tag   = '0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            exp_resp[p] = '0;
            exp_tag[p]  = '0;
            exp_data[p] = '0;
        end
        last_g = NP - 1;
    endtask

    // Predicts what the coming clock edge does given the inputs now applied.
    task automatic model_edge();
        int            g;
        int            c;
        mreq_t         r;
        logic [1:0]    rr;
        logic [DW-1:0] rd;
        g = -1;
        for (int p = 0; p < NP; p++) begin
            exp_ready[p] = (mq[p].size() < DEPTH);
            exp_resp[p]  = '0;
            exp_tag[p]   = '0;
            exp_data[p]  = '0;
        end
        for (int i = 1; i <= NP; i++) begin
            c = (last_g + i) % NP;
            if (g < 0 && mq[c].size() > 0) g = c;
        end
        if (g >= 0) begin
            r = mq[g].pop_front();
            ref_alu(r.cmd, r.d1, r.d2, rr, rd);
            exp_resp[g] = rr;
            exp_tag[g]  = r.tag;
            exp_data[g] = rd;
            last_g      = g;
        end
        for (int p = 0; p < NP; p++) begin
            if (req_cmd[p*4 +: 4] != 4'd0 && exp_ready[p]) begin
                r.cmd = req_cmd[p*4 +: 4];
                r.d1  = req_data1[p*DW +: DW];
                r.d2  = req_data2[p*DW +: DW];
                r.tag = req_tag[p*TW +: TW];
                mq[p].push_back(r);
            end
        end
    endtask

    task automatic cycle();
        seen_ready = req_ready;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b1;
        clear_reqs();
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (out_resp !== '0 || out_tag !== '0 || out_data !== '0 || req_ready !== 4'hF) begin
                n_miss++;
                $display("[TB] FAIL reset_state %0d: got resp=%h tag=%h ready=%h, want resp=0 tag=0 ready=f",
                         k, out_resp, out_tag, req_ready);
            end
            if (k == 0) apply_reset();
        end
    endtask

    task automatic test_basic_add();
        $display("[TB] test_basic_add");
        set_req(0, 4'd1, 32'd5, 32'd3, 2'd1);
        cycle();
        clear_reqs();
        cycle();
        n_vec++;
        if (out_resp[1:0] !== 2'd1 || out_data[31:0] !== 32'd8 || out_tag[1:0] !== 2'd1) begin
            n_miss++;
            $display("[TB] FAIL add_5_3: got resp=%0d data=%0d tag=%0d, want resp=1 data=8 tag=1",
                     out_resp[1:0], out_data[31:0], out_tag[1:0]);
        end
        n_vec++;
        if (out_resp[7:2] !== 6'd0) begin
            n_miss++;
            $display("[TB] FAIL add_others_idle: got resp[3:1]=%h, want 0", out_resp[7:2]);
        end
        cycle();
        n_vec++;
        if (out_resp !== '0 || out_data !== '0) begin
            n_miss++;
            $display("[TB] FAIL add_pulse_clear: got resp=%h, want 0", out_resp);
        end
    endtask

    task automatic test_errors();
        $display("[TB] test_errors");
        set_req(1, 4'd4, 32'd7, 32'd7, 2'd1);
        set_req(2, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2);
        set_req(3, 4'd2, 32'd3, 32'd5, 2'd3);
        cycle();
        clear_reqs();
        for (int j = 1; j <= 3; j++) begin
            cycle();
            n_vec++;
            if (out_resp[j*2 +: 2] !== 2'd2 || out_data[j*DW +: DW] !== 32'd0 || out_tag[j*TW +: TW] !== TW'(j)) begin
                n_miss++;
                $display("[TB] FAIL err_port%0d: got resp=%0d data=%h tag=%0d, want resp=2 data=0 tag=%0d",
                         j, out_resp[j*2 +: 2], out_data[j*DW +: DW], out_tag[j*TW +: TW], j);
            end
        end
    endtask

    task automatic test_shift();
        logic [1:0]  w_resp [2];
        logic [31:0] w_data [2];
        $display("[TB] test_shift");
`ifdef CALCN_SHIFT_EN
        w_resp[0] = 2'd1; w_data[0] = 32'd16;
        w_resp[1] = 2'd1; w_data[1] = 32'd1;
`else
        w_resp[0] = 2'd2; w_data[0] = 32'd0;
        w_resp[1] = 2'd2; w_data[1] = 32'd0;
`endif
        set_req(0, 4'd5, 32'd1, 32'd4, 2'd0);
        set_req(1, 4'd6, 32'h8000_0000, 32'd31, 2'd1);
        cycle();
        clear_reqs();
        for (int j = 0; j < 2; j++) begin
            cycle();
            n_vec++;
            if (out_resp[j*2 +: 2] !== w_resp[j] || out_data[j*DW +: DW] !== w_data[j]) begin
                n_miss++;
                $display("[TB] FAIL shift_port%0d: got resp=%0d data=%h, want resp=%0d data=%h",
                         j, out_resp[j*2 +: 2], out_data[j*DW +: DW], w_resp[j], w_data[j]);
            end
        end
    endtask

    task automatic test_all_ports();
        $display("[TB] test_all_ports");
        apply_reset();
        for (int p = 0; p < NP; p++) set_req(p, 4'd1, 32'(p), 32'(p * 10), TW'(p));
        cycle();
        clear_reqs();
        for (int j = 0; j < NP; j++) begin
            cycle();
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (out_resp[p*2 +: 2] !== ((p == j) ? 2'd1 : 2'd0) ||
                    out_data[p*DW +: DW] !== ((p == j) ? 32'(11 * j) : 32'd0) ||
                    out_tag[p*TW +: TW] !== ((p == j) ? TW'(j) : TW'(0))) begin
                    n_miss++;
                    $display("[TB] FAIL rr_cycle%0d_port%0d: got resp=%0d data=%0d, want port %0d only",
                             j, p, out_resp[p*2 +: 2], out_data[p*DW +: DW], j);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] cmds [8];
        int         guard;
        $display("[TB] test_back_to_back");
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd1, 4'd2, 4'd1};
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < NP; p++)
                set_req(p, cmds[$urandom_range(0, 7)], $urandom, $urandom_range(0, 40), TW'(i));
            cycle();
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (out_resp[p*2 +: 2] !== exp_resp[p] || out_tag[p*TW +: TW] !== exp_tag[p] ||
                    out_data[p*DW +: DW] !== exp_data[p]) begin
                    n_miss++;
                    $display("[TB] FAIL b2b_out port %0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                             p, out_resp[p*2 +: 2], out_tag[p*TW +: TW], out_data[p*DW +: DW],
                             exp_resp[p], exp_tag[p], exp_data[p]);
                end
            end
            n_vec++;
            if (seen_ready !== exp_ready) begin
                n_miss++;
                $display("[TB] FAIL b2b_ready: got %b, want %b", seen_ready, exp_ready);
            end
        end
        clear_reqs();
        guard = 0;
        while (model_busy() && guard < 40) begin
            cycle();
            guard++;
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (out_resp[p*2 +: 2] !== exp_resp[p] || out_tag[p*TW +: TW] !== exp_tag[p] ||
                    out_data[p*DW +: DW] !== exp_data[p]) begin
                    n_miss++;
                    $display("[TB] FAIL drain_out port %0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                             p, out_resp[p*2 +: 2], out_tag[p*TW +: TW], out_data[p*DW +: DW],
                             exp_resp[p], exp_tag[p], exp_data[p]);
                end
            end
        end
        if (guard >= 40) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain_timeout: got %0d cycles, want drain within 40", guard);
        end
    endtask

    task automatic test_random();
        logic [3:0] cmds [8];
        $display("[TB] test_random");
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd1, 4'd2, 4'd15};
        for (int i = 0; i < 150; i++) begin
            clear_reqs();
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(p, cmds[$urandom_range(0, 7)], $urandom, $urandom, TW'($urandom));
            end
            cycle();
            for (int p = 0; p < NP; p++) begin
                n_vec++;
                if (out_resp[p*2 +: 2] !== exp_resp[p] || out_tag[p*TW +: TW] !== exp_tag[p] ||
                    out_data[p*DW +: DW] !== exp_data[p]) begin
                    n_miss++;
                    $display("[TB] FAIL rand_out cyc %0d port %0d: got resp=%0d tag=%0d data=%h, want resp=%0d tag=%0d data=%h",
                             i, p, out_resp[p*2 +: 2], out_tag[p*TW +: TW], out_data[p*DW +: DW],
                             exp_resp[p], exp_tag[p], exp_data[p]);
                end
            end
            n_vec++;
            if (seen_ready !== exp_ready) begin
                n_miss++;
                $display("[TB] FAIL rand_ready cyc %0d: got %b, want %b", i, seen_ready, exp_ready);
            end
        end
        clear_reqs();
    endtask

    task automatic test_reset_midflight();
        $display("[TB] test_reset_midflight");
        apply_reset();
        // Four cycles of all-port traffic leave three entries queued on port 1.
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < NP; p++) set_req(p, 4'd1, 32'(i), 32'(p), TW'(i));
            cycle();
        end
        clear_reqs();
        n_vec++;
        if (out_resp === '0) begin
            n_miss++;
            $display("[TB] FAIL midflight_busy: got resp=%h, want a response on port 2", out_resp);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_resp !== '0 || out_tag !== '0 || out_data !== '0 || req_ready !== 4'hF) begin
            n_miss++;
            $display("[TB] FAIL async_clear: got resp=%h data=%h ready=%h, want resp=0 data=0 ready=f",
                     out_resp, out_data, req_ready);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        set_req(1, 4'd1, 32'd1, 32'd1, 2'd1);
        set_req(0, 4'd1, 32'd2, 32'd2, 2'd2);
        cycle();
        clear_reqs();
        cycle();
        n_vec++;
        if (out_resp !== 8'h01 || out_data[31:0] !== 32'd4 || out_tag[1:0] !== 2'd2) begin
            n_miss++;
            $display("[TB] FAIL post_reset_first: got resp=%h data0=%0d tag0=%0d, want resp=01 data0=4 tag0=2",
                     out_resp, out_data[31:0], out_tag[1:0]);
        end
        cycle();
        n_vec++;
        if (out_resp !== 8'h04 || out_data[63:32] !== 32'd2) begin
            n_miss++;
            $display("[TB] FAIL post_reset_second: got resp=%h data1=%0d, want resp=04 data1=2",
                     out_resp, out_data[63:32]);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_vec++;
            if (out_resp !== '0) begin
                n_miss++;
                $display("[TB] FAIL stale_resp %0d: got resp=%h, want 0", k, out_resp);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_basic_add();
        test_errors();
        test_shift();
        test_all_ports();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
